// File: rtl/idex_skid_pipe.sv
// ---------------------------------------------------------------------------
// idex_skid_pipe
//
// Elastic decode-to-execute pipeline stage. It replaces a hold-vector register
// stage with a DEPTH-entry circular skid buffer and valid/ready flow control.
// The payload is opaque: the instantiating module packs instruction, address,
// register/CSR addresses, decode info and immediate into in_data_i.
//
// Parameters:
//   DATA_W    payload width (>=1)
//   DEPTH     number of buffer entries (1..4)
//   IDLE_VAL  value shown on out_data_o while the stage is empty (NOP payload)
//   CNT_W     occupancy count width, $clog2(DEPTH+1)
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   upstream payload valid
//   in_ready_o   stage can accept a payload this cycle (registered state only)
//   in_data_i    upstream payload
//   out_valid_o  head entry valid
//   out_ready_i  downstream accepts the head entry
//   out_data_o   head payload, IDLE_VAL when out_valid_o=0
//   flush_i      synchronous flush, discards every entry
//   count_o      current number of valid entries
// ---------------------------------------------------------------------------
module idex_skid_pipe #(
  parameter int                DATA_W   = 256,
  parameter int                DEPTH    = 2,
  parameter logic [DATA_W-1:0] IDLE_VAL = '0,
  parameter int                CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // Pointers wrap by explicit compare so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  // Ready depends only on the registered count, so there is no path from
  // out_ready_i to in_ready_o. This is what limits DEPTH=1 to half rate.
  assign in_ready_o  = (count < FULL_CNT);
  assign out_valid_o = (count != '0);

  // A flush cycle swallows both handshakes, so neither side may treat its
  // transfer as done.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  // Storage is never reset, so the empty stage is masked to the NOP payload.
  assign out_data_o = out_valid_o ? mem[rd_ptr] : IDLE_VAL;
  assign count_o    = count;

  // Pointer and occupancy state; flush has priority over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload RAM, write-only on push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data_i;
    end
  end

  // The handshake should make overflow and underflow impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    count <= FULL_CNT);
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !push && (count == '0)));

endmodule

// File: tb/tb_idex_skid_pipe.sv
// ---------------------------------------------------------------------------
// tb_idex_skid_pipe
//
// Bench for idex_skid_pipe. Two instances share clock and reset: index 0 has
// DEPTH=2 (directed tests), index 1 has DEPTH=3 (randomised wrap test). Each
// instance has a queue-based reference model holding the expected contents;
// outputs are predicted from queue size and head alone.
// ---------------------------------------------------------------------------
module tb_idex_skid_pipe;

  localparam int          DW   = 32;
  localparam logic [31:0] IDLE = 32'hDEAD_0013;

  logic          clk;
  logic          rst_n;
  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [DW-1:0] in_data  [2];
  logic [1:0]    out_valid;
  logic [1:0]    out_ready;
  logic [DW-1:0] out_data [2];
  logic [1:0]    flush;
  logic [1:0]    count    [2];

  int checks;
  int errors;

  // Reference contents of each instance, head at index 0.
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];

  idex_skid_pipe #(.DATA_W(DW), .DEPTH(2), .IDLE_VAL(IDLE)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid[0]),
    .in_ready_o  (in_ready[0]),
    .in_data_i   (in_data[0]),
    .out_valid_o (out_valid[0]),
    .out_ready_i (out_ready[0]),
    .out_data_o  (out_data[0]),
    .flush_i     (flush[0]),
    .count_o     (count[0])
  );

  idex_skid_pipe #(.DATA_W(DW), .DEPTH(3), .IDLE_VAL(IDLE)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid[1]),
    .in_ready_o  (in_ready[1]),
    .in_data_i   (in_data[1]),
    .out_valid_o (out_valid[1]),
    .out_ready_i (out_ready[1]),
    .out_data_o  (out_data[1]),
    .flush_i     (flush[1]),
    .count_o     (count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  // Compare one instance's outputs against its model.
  task automatic checkOutput(input int k);
    int            sz;
    int            depth;
    logic [DW-1:0] head;
    sz    = (k == 0) ? q0.size() : q1.size();
    depth = (k == 0) ? 2 : 3;
    head  = IDLE;
    if (sz > 0) head = (k == 0) ? q0[0] : q1[0];

    checks++;
    assert (out_valid[k] === (sz != 0)) else begin
      errors++;
      $error("[TB] FAIL out_valid[%0d]: observed %b expected %b", k, out_valid[k], (sz != 0));
    end
    checks++;
    assert (out_data[k] === head) else begin
      errors++;
      $error("[TB] FAIL out_data[%0d]: observed %h expected %h", k, out_data[k], head);
    end
    checks++;
    assert (count[k] === 2'(sz)) else begin
      errors++;
      $error("[TB] FAIL count[%0d]: observed %0d expected %0d", k, count[k], sz);
    end
    checks++;
    assert (in_ready[k] === (sz < depth)) else begin
      errors++;
      $error("[TB] FAIL in_ready[%0d]: observed %b expected %b", k, in_ready[k], (sz < depth));
    end
  endtask

  // One cycle: drive instance sel (other instance idle), check both, then
  // advance the models across the clock edge. Entered and left at posedge+1.
  task automatic applyStimulus(input int sel, input logic v, input logic [DW-1:0] d,
                               input logic r, input logic f);
    logic push0, pop0, push1, pop1;
    in_valid  = '0;
    out_ready = '0;
    flush     = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    in_valid[sel]  = v;
    out_ready[sel] = r;
    flush[sel]     = f;
    in_data[sel]   = d;
    checkOutput(0);
    checkOutput(1);

    push0 = in_valid[0] && (q0.size() < 2) && !flush[0];
    pop0  = out_ready[0] && (q0.size() > 0) && !flush[0];
    push1 = in_valid[1] && (q1.size() < 3) && !flush[1];
    pop1  = out_ready[1] && (q1.size() > 0) && !flush[1];

    @(posedge clk);
    if (rst_n) begin
      if (flush[0]) q0.delete();
      else begin
        if (pop0)  void'(q0.pop_front());
        if (push0) q0.push_back(in_data[0]);
      end
      if (flush[1]) q1.delete();
      else begin
        if (pop1)  void'(q1.pop_front());
        if (push1) q1.push_back(in_data[1]);
      end
    end
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    flush     = '0;
    in_data[0] = '0;
    in_data[1] = '0;

    // Reset held for 3 cycles, checked during reset.
    #1;
    checkOutput(0);
    checkOutput(1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput(0);
      checkOutput(1);
    end
    rst_n = 1'b1;

    // Idle after release.
    for (int i = 0; i < 10; i++) applyStimulus(0, 1'b0, '0, 1'b0, 1'b0);

    // Streaming 0x1..0x20 back-to-back on DEPTH=2.
    for (int i = 1; i <= 32; i++) applyStimulus(0, 1'b1, DW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: A, B accepted, C held upstream until room appears.
    applyStimulus(0, 1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'hB, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'hC, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'hC, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'hC, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 32'hC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);

    // Flush with full buffer and a competing push and pop.
    applyStimulus(0, 1'b1, 32'h11, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h22, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h33, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);

    // Randomised traffic on DEPTH=3 across many pointer wraps.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1, ($urandom_range(3) != 0), $urandom(),
                    ($urandom_range(2) != 0), ($urandom_range(63) == 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with two entries held.
    applyStimulus(0, 1'b1, 32'h77, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h88, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h99, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    checkOutput(0);
    checkOutput(1);
    @(posedge clk);
    #1;
    checkOutput(0);
    checkOutput(1);
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 32'h5A, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
